// File: rtl/rob_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rob_pkg
// Brief   : Shared defaults and entry record for the reorder buffer.
// Rev     : 1.0  initial release
// ============================================================================
package rob_pkg;

   localparam int c_DEPTH  = 16;
   localparam int c_XLEN   = 32;
   localparam int c_RIDX_W = 5;

   // Storage fields are sized for the widest supported build.
   // Narrower XLEN/RIDX_W builds zero-extend into them.
   localparam int c_XLEN_MAX   = 64;
   localparam int c_RIDX_W_MAX = 8;

   typedef struct packed {
      logic                    busy;
      logic                    ready;
      logic                    mispred;
      logic [c_RIDX_W_MAX-1:0] rd;
      logic [c_XLEN_MAX-1:0]   val;
      logic [31:0]             pc;
   } rob_entry_t;

endpackage
`default_nettype wire

// File: rtl/rob_ptr.sv
`default_nettype none
// ============================================================================
// Module  : rob_ptr
// Brief   : Wrap-bit circular pointer with increment and synchronous clear.
// Rev     : 1.0  initial release
// ============================================================================
module rob_ptr
   import rob_pkg::*;
#(
   parameter int TAG_W = 4
) (
   input  logic           clk_in,
   input  logic           rst_in,
   input  logic           inc,
   input  logic           clr,
   output logic [TAG_W:0] ptr
);

   logic [TAG_W:0] r_ptr;

   // Clear takes priority so a flush always lands on index zero.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_ptr <= '0;
      end else if (clr) begin
         r_ptr <= '0;
      end else if (inc) begin
         r_ptr <= r_ptr + (TAG_W+1)'(1);
      end
   end

   assign ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/reorder_buf.sv
`default_nettype none
// ============================================================================
// Module  : reorder_buf
// Brief   : In-order commit reorder buffer with mispredict flush.
//           Define ROB_QUERY_EN to add two combinational rename lookup ports.
//           XLEN up to 64 and RIDX_W up to 8 are supported.
// Rev     : 1.0  initial release
// ============================================================================
module reorder_buf
   import rob_pkg::*;
#(
   parameter  int DEPTH  = c_DEPTH,
   parameter  int XLEN   = c_XLEN,
   parameter  int RIDX_W = c_RIDX_W,
   localparam int TAG_W  = $clog2(DEPTH)
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              alloc_valid,
   input  logic [RIDX_W-1:0] alloc_rd,
   output logic [TAG_W-1:0]  alloc_tag,
   output logic              full,
   output logic [TAG_W:0]    count,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [XLEN-1:0]   cdb_val,
   input  logic              cdb_mispred,
   input  logic [31:0]       cdb_pc,
   output logic              commit_valid,
   output logic              commit_we,
   output logic [RIDX_W-1:0] commit_rd,
   output logic [XLEN-1:0]   commit_val,
   output logic [TAG_W-1:0]  commit_tag,
`ifdef ROB_QUERY_EN
   input  logic [TAG_W-1:0]  qry0_tag,
   output logic              qry0_ready,
   output logic [XLEN-1:0]   qry0_val,
   input  logic [TAG_W-1:0]  qry1_tag,
   output logic              qry1_ready,
   output logic [XLEN-1:0]   qry1_val,
`endif
   output logic              flush_out,
   output logic [31:0]       flush_pc
);

   rob_entry_t        r_rob [DEPTH];
   rob_entry_t        w_head_ent;
   logic [TAG_W:0]    w_head;
   logic [TAG_W:0]    w_tail;
   logic [TAG_W-1:0]  w_head_idx;
   logic              w_commit;
   logic              w_flush;
   logic              w_alloc;
   logic              w_wb;

   logic              r_commit_valid;
   logic [RIDX_W-1:0] r_commit_rd;
   logic [XLEN-1:0]   r_commit_val;
   logic [TAG_W-1:0]  r_commit_tag;
   logic              r_flush;
   logic [31:0]       r_flush_pc;

   assign w_head_idx = w_head[TAG_W-1:0];
   assign w_head_ent = r_rob[w_head_idx];

   assign full      = (w_head_idx == w_tail[TAG_W-1:0]) && (w_head[TAG_W] != w_tail[TAG_W]);
   assign count     = w_tail - w_head;
   assign alloc_tag = w_tail[TAG_W-1:0];

   // A flushing edge discards every other request of that cycle.
   assign w_commit = rdy_in && w_head_ent.busy && w_head_ent.ready;
   assign w_flush  = w_commit && w_head_ent.mispred;
   assign w_alloc  = rdy_in && alloc_valid && !full && !w_flush;
   assign w_wb     = rdy_in && cdb_valid && r_rob[cdb_tag].busy && !w_flush;

   rob_ptr #(.TAG_W(TAG_W)) u_head (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .inc    (w_commit),
      .clr    (w_flush),
      .ptr    (w_head)
   );

   rob_ptr #(.TAG_W(TAG_W)) u_tail (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .inc    (w_alloc),
      .clr    (w_flush),
      .ptr    (w_tail)
   );

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_rob[i] <= '0;
         end
      end else if (w_flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_rob[i].busy  <= 1'b0;
            r_rob[i].ready <= 1'b0;
         end
      end else begin
         if (w_wb) begin
            r_rob[cdb_tag].ready   <= 1'b1;
            r_rob[cdb_tag].val     <= c_XLEN_MAX'(cdb_val);
            r_rob[cdb_tag].mispred <= cdb_mispred;
            r_rob[cdb_tag].pc      <= cdb_pc;
         end
         // Placed after the writeback so a retiring entry always ends idle.
         if (w_commit) begin
            r_rob[w_head_idx].busy  <= 1'b0;
            r_rob[w_head_idx].ready <= 1'b0;
         end
         if (w_alloc) begin
            r_rob[alloc_tag].busy    <= 1'b1;
            r_rob[alloc_tag].ready   <= 1'b0;
            r_rob[alloc_tag].mispred <= 1'b0;
            r_rob[alloc_tag].rd      <= c_RIDX_W_MAX'(alloc_rd);
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_commit_valid <= 1'b0;
         r_commit_rd    <= '0;
         r_commit_val   <= '0;
         r_commit_tag   <= '0;
         r_flush        <= 1'b0;
         r_flush_pc     <= '0;
      end else begin
         r_commit_valid <= w_commit;
         r_flush        <= w_flush;
         if (w_commit) begin
            r_commit_rd  <= RIDX_W'(w_head_ent.rd);
            r_commit_val <= XLEN'(w_head_ent.val);
            r_commit_tag <= w_head_idx;
         end
         if (w_flush) begin
            r_flush_pc <= w_head_ent.pc;
         end
      end
   end

   assign commit_valid = r_commit_valid;
   assign commit_we    = r_commit_valid && (r_commit_rd != '0);
   assign commit_rd    = r_commit_rd;
   assign commit_val   = r_commit_val;
   assign commit_tag   = r_commit_tag;
   assign flush_out    = r_flush;
   assign flush_pc     = r_flush_pc;

`ifdef ROB_QUERY_EN
   logic w_q0_fwd;
   logic w_q1_fwd;

   // Same-cycle writeback is forwarded so rename never sees a stale entry.
   assign w_q0_fwd   = w_wb && (cdb_tag == qry0_tag);
   assign w_q1_fwd   = w_wb && (cdb_tag == qry1_tag);
   assign qry0_ready = w_q0_fwd || r_rob[qry0_tag].ready;
   assign qry1_ready = w_q1_fwd || r_rob[qry1_tag].ready;
   assign qry0_val   = w_q0_fwd ? cdb_val : XLEN'(r_rob[qry0_tag].val);
   assign qry1_val   = w_q1_fwd ? cdb_val : XLEN'(r_rob[qry1_tag].val);
`endif

endmodule
`default_nettype wire

// File: tb/tb_reorder_buf.sv
`default_nettype none
// ============================================================================
// Module  : tb_reorder_buf
// Brief   : Directed plus random checks of reorder_buf against a queue model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_reorder_buf;

   localparam int DEPTH  = 16;
   localparam int XLEN   = 32;
   localparam int RIDX_W = 5;
   localparam int TAG_W  = 4;

   logic              clk_in = 1'b0;
   logic              rst_in = 1'b0;
   logic              rdy_in = 1'b0;
   logic              alloc_valid = 1'b0;
   logic [RIDX_W-1:0] alloc_rd = '0;
   logic [TAG_W-1:0]  alloc_tag;
   logic              full;
   logic [TAG_W:0]    count;
   logic              cdb_valid = 1'b0;
   logic [TAG_W-1:0]  cdb_tag = '0;
   logic [XLEN-1:0]   cdb_val = '0;
   logic              cdb_mispred = 1'b0;
   logic [31:0]       cdb_pc = '0;
   logic              commit_valid;
   logic              commit_we;
   logic [RIDX_W-1:0] commit_rd;
   logic [XLEN-1:0]   commit_val;
   logic [TAG_W-1:0]  commit_tag;
   logic              flush_out;
   logic [31:0]       flush_pc;
`ifdef ROB_QUERY_EN
   logic [TAG_W-1:0]  qry0_tag = '0;
   logic              qry0_ready;
   logic [XLEN-1:0]   qry0_val;
   logic [TAG_W-1:0]  qry1_tag = '0;
   logic              qry1_ready;
   logic [XLEN-1:0]   qry1_val;
`endif

   always #5 clk_in = ~clk_in;

   reorder_buf #(.DEPTH(DEPTH), .XLEN(XLEN), .RIDX_W(RIDX_W)) dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .rdy_in       (rdy_in),
      .alloc_valid  (alloc_valid),
      .alloc_rd     (alloc_rd),
      .alloc_tag    (alloc_tag),
      .full         (full),
      .count        (count),
      .cdb_valid    (cdb_valid),
      .cdb_tag      (cdb_tag),
      .cdb_val      (cdb_val),
      .cdb_mispred  (cdb_mispred),
      .cdb_pc       (cdb_pc),
      .commit_valid (commit_valid),
      .commit_we    (commit_we),
      .commit_rd    (commit_rd),
      .commit_val   (commit_val),
      .commit_tag   (commit_tag),
`ifdef ROB_QUERY_EN
      .qry0_tag     (qry0_tag),
      .qry0_ready   (qry0_ready),
      .qry0_val     (qry0_val),
      .qry1_tag     (qry1_tag),
      .qry1_ready   (qry1_ready),
      .qry1_val     (qry1_val),
`endif
      .flush_out    (flush_out),
      .flush_pc     (flush_pc)
   );

   // Model: program-order list of in-flight instructions, oldest first.
   typedef struct {
      int          tag;
      int          rd;
      bit          ready;
      logic [31:0] val;
      bit          mis;
      logic [31:0] pc;
   } ment_t;

   ment_t       q[$];
   int          tail_idx = 0;
   logic [31:0] exp_flush_pc = '0;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: apply inputs, check occupancy, advance the model, check commit.
   task automatic cycle(input bit rdy, input bit av, input int rd, input bit cv,
                        input int ctag, input logic [31:0] cval, input bit cmis,
                        input logic [31:0] cpc);
      bit    was_full;
      bit    com;
      bit    fl;
      ment_t h;
      rdy_in      = rdy;
      alloc_valid = av;
      alloc_rd    = rd[RIDX_W-1:0];
      cdb_valid   = cv;
      cdb_tag     = ctag[TAG_W-1:0];
      cdb_val     = cval;
      cdb_mispred = cmis;
      cdb_pc      = cpc;
      chk("count", count, q.size());
      chk("full", full, q.size() == DEPTH);
      chk("alloc_tag", alloc_tag, tail_idx);
      was_full = (q.size() == DEPTH);
      com      = rdy && q.size() > 0 && q[0].ready;
      if (com) h = q[0];
      fl = com && h.mis;
      if (fl) begin
         q.delete();
         tail_idx     = 0;
         exp_flush_pc = h.pc;
      end else if (rdy) begin
         if (cv) begin
            foreach (q[i]) begin
               if (q[i].tag == ctag) begin
                  q[i].ready = 1'b1;
                  q[i].val   = cval;
                  q[i].mis   = cmis;
                  q[i].pc    = cpc;
               end
            end
         end
         if (com) void'(q.pop_front());
         if (av && !was_full) begin
            q.push_back('{tail_idx, rd, 1'b0, 32'h0, 1'b0, 32'h0});
            tail_idx = (tail_idx + 1) % DEPTH;
         end
      end
      @(posedge clk_in);
      #1;
      chk("commit_valid", commit_valid, com);
      chk("flush_out", flush_out, fl);
      chk("flush_pc", flush_pc, exp_flush_pc);
      if (com) begin
         chk("commit_tag", commit_tag, h.tag);
         chk("commit_rd", commit_rd, h.rd);
         chk("commit_val", commit_val, h.val);
         chk("commit_we", commit_we, h.rd != 0);
      end else begin
         chk("commit_we_idle", commit_we, 0);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic alloc(input int rd);
      cycle(1, 1, rd, 0, 0, 0, 0, 0);
   endtask

   task automatic wb(input int tag, input logic [31:0] val);
      cycle(1, 0, 0, 1, tag, val, 0, 0);
   endtask

   // Writes back the oldest pending entry each cycle until the model is empty.
   task automatic drain();
      int pend;
      for (int n = 0; n < 200 && q.size() > 0; n++) begin
         pend = -1;
         foreach (q[i]) if (pend < 0 && !q[i].ready) pend = q[i].tag;
         if (pend >= 0) wb(pend, $urandom);
         else idle(1);
      end
      chk("drain_count", count, 0);
   endtask

   task automatic reset_dut();
      rst_in      = 1'b0;
      alloc_valid = 1'b0;
      cdb_valid   = 1'b0;
      @(posedge clk_in);
      #1;
      rst_in = 1'b1;
      q.delete();
      tail_idx     = 0;
      exp_flush_pc = '0;
   endtask

   initial begin
      int t;
      // Reset state
      rdy_in = 1'b1;
      repeat (2) @(posedge clk_in);
      #1;
      chk("rst_count", count, 0);
      chk("rst_full", full, 0);
      chk("rst_alloc_tag", alloc_tag, 0);
      chk("rst_commit_valid", commit_valid, 0);
      chk("rst_flush_out", flush_out, 0);
      chk("rst_flush_pc", flush_pc, 0);
      rst_in = 1'b1;

      // Fill: 17th alloc ignored
      for (int i = 0; i < 17; i++) alloc(i + 1);
      chk("fill_full", full, 1);
      chk("fill_count", count, 16);
      for (int i = 15; i >= 1; i--) wb(i, 32'h100 + i);
      wb(0, 32'h100);
      // Full before the edge, so this alloc is dropped even though head retires.
      alloc(7);
      drain();

      // Out-of-order writeback, in-order commit; then an rd=0 entry
      reset_dut();
      alloc(1); alloc(2); alloc(3);
      wb(2, 32'h33); wb(1, 32'h22); wb(0, 32'h11);
      idle(4);
      alloc(0);
      drain();

      // Mispredict on tag 1 with tags 2-3 still busy
      reset_dut();
      for (int i = 0; i < 4; i++) alloc(i + 4);
      wb(0, 32'hA0);
      cycle(1, 0, 0, 1, 1, 32'hA1, 1, 32'h100);
      cycle(1, 1, 9, 1, 2, 32'hDEAD, 0, 0);
      chk("flush_pc_0x100", flush_pc, 32'h100);
      idle(2);

      // Wrap: 20 alloc/commit pairs streaming through index 15 -> 0
      for (int k = 0; k < 22; k++) begin
         cycle(1, k < 20, (k % 31) + 1, (k > 0) && (k <= 20), (k - 1) % DEPTH,
               32'hC00 + k, 0, 0);
      end
      drain();

      // Enable low freezes everything
      alloc(3); alloc(4);
      cycle(0, 1, 5, 1, q[1].tag, 32'h77, 0, 0);
      wb(q[0].tag, 32'h66);
      cycle(0, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 0);
      idle(1);
      drain();

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         t = $urandom_range(DEPTH - 1, 0);
         if (q.size() > 0 && $urandom_range(3, 0) != 0) t = q[$urandom_range(q.size() - 1, 0)].tag;
         cycle($urandom_range(9, 0) != 0, $urandom_range(9, 0) < 6, $urandom_range(31, 0),
               $urandom_range(1, 0), t, $urandom, $urandom_range(15, 0) == 0, $urandom | 32'h4);
      end
      drain();
      // Guarantees a nonzero flush_pc ahead of the asynchronous reset
      alloc(2);
      cycle(1, 0, 0, 1, q[0].tag, 32'h5, 1, 32'h2468);
      idle(1);

      // Asynchronous reset mid-cycle with 5 entries busy
      for (int i = 0; i < 6; i++) alloc(i + 10);
      wb(q[2].tag, 32'h52);
      wb(q[0].tag, 32'h50);
      wb(q[3].tag, 32'h53);
      chk("pre_rst_count", count, 5);
      #2;
      rst_in = 1'b0;
      #1;
      chk("async_commit_valid", commit_valid, 0);
      chk("async_commit_we", commit_we, 0);
      chk("async_commit_rd", commit_rd, 0);
      chk("async_commit_val", commit_val, 0);
      chk("async_commit_tag", commit_tag, 0);
      chk("async_flush_out", flush_out, 0);
      chk("async_flush_pc", flush_pc, 0);
      chk("async_count", count, 0);
      @(posedge clk_in);
      #1;
      rst_in = 1'b1;
      q.delete();
      tail_idx     = 0;
      exp_flush_pc = '0;
      idle(4);
      alloc(1); alloc(2);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
